operand_loader: RTL and testbench
=================================

// Module: operand_loader
// PURPOSE
//  Front-end for the switch-driven ALU datapath. Debounces one push-button and
//  steps a 3-state FSM that captures operand A, operand B, then the opcode from
//  the shared data switches on successive presses. Drives the ALU operand and
//  opcode registers directly. Pulses o_valid once each time a full triple has
//  been captured.
// PARAMETERS
//  NB_DATA     4        operand width; A/B take i_dato[NB_DATA-1:0]
//  NB_OP       6        opcode width and i_dato width (NB_OP >= NB_DATA)
//  DEB_CYCLES  1000000  consecutive stable cycles needed to accept a level (>=1)
// PORTS
//  clk       in   1        system clock, all logic on posedge
//  i_rst_n   in   1        reset: asynchronous, active-low
//  i_btn     in   1        raw push-button, asynchronous, bouncy, active-high
//  i_dato    in   NB_OP    data switches, treated as quasi-static
//  o_datoA   out  NB_DATA  captured operand A
//  o_datoB   out  NB_DATA  captured operand B
//  o_op      out  NB_OP    captured opcode
//  o_valid   out  1        1-cycle pulse: triple complete
//  o_state   out  2        FSM state for LEDs: 00=S_A 01=S_B 10=S_OP
// BEHAVIOUR
//  Reset (async, active-low)
//   - Clears o_datoA, o_datoB, o_op, o_valid, sync flops, counter, deb, deb_d.
//   - FSM goes to S_A, so o_state=00.
//   - Reset mid-sequence discards any partial capture.
//  Synchronizer
//   - Two flops on i_btn; s2 is the synchronized level.
//  Debounce
//   - Counter width $clog2(DEB_CYCLES+1).
//   - s2==deb: counter<=0.
//   - s2!=deb and counter==DEB_CYCLES-1: deb<=s2, counter<=0.
//   - Otherwise counter increments.
//   - Any glitch shorter than DEB_CYCLES cycles is ignored.
//  Press event
//   - press = deb & ~deb_d, with deb_d registered. Exactly one per accepted
//     rising level. Release produces no event.
//   - Holding the button produces one event only.
//   - Button held through reset release yields one press after debounce,
//     because deb resets to 0.
//  FSM (advances only on press; no press = hold state)
//   - S_A : on press, o_datoA <= i_dato[NB_DATA-1:0]; go S_B.
//   - S_B : on press, o_datoB <= i_dato[NB_DATA-1:0]; go S_OP.
//   - S_OP: on press, o_op <= i_dato; o_valid <= 1; go S_A.
//   - Encoding 11 is illegal; it recovers to S_A on the next edge with no load.
//  Outputs
//   - o_valid is registered, high exactly 1 cycle, on the same edge o_op updates.
//   - Captured registers hold their value until the next capture in their state
//     or until reset. A new A capture does not clear B or op.
//  Latency and sampling
//   - i_btn stably high from before edge 1: deb rises at edge DEB_CYCLES+2,
//     register loads at edge DEB_CYCLES+3.
//   - i_dato is sampled only at the load edge; earlier changes are irrelevant.
// TESTING (DEB_CYCLES=4 in bench)
//  1 Reset, then no button activity
//    -> all outputs 0, o_state=00, no o_valid for 100 cycles.
//  2 i_dato=0x05 press, 0x03 press, 0x20 press (each held 10 cycles)
//    -> A=5, B=3, op=0x20; o_valid high exactly 1 cycle; o_state 00->01->10->00.
//  3 Latency: stable press starting before edge 1
//    -> A loads at edge 7, not 6.
//  4 Bounce: 3-cycle high glitches x5, then 20-cycle hold
//    -> exactly one capture; state advances by one.
//  5 Reset asserted mid-cycle while in S_B with A=0x9
//    -> A=0 immediately (async), o_state=00; next press loads A.
//  6 Press held 200 cycles, i_dato changed 0x01->0x0F after load
//    -> single load of 0x1; no further loads until release and re-press.

Source files
------------

// File: rtl/operand_loader_if.sv
// Button, switch and captured-operand signals shared between the loader and its consumer.
// Slave is the loader side; master drives the button/switches and observes the captures.
interface operand_loader_if #(
    parameter int NB_DATA = 4,
    parameter int NB_OP   = 6
);
    logic               i_btn;
    logic [NB_OP-1:0]   i_dato;
    logic [NB_DATA-1:0] o_datoA;
    logic [NB_DATA-1:0] o_datoB;
    logic [NB_OP-1:0]   o_op;
    logic               o_valid;
    logic [1:0]         o_state;

    modport slave (
        input  i_btn,
        input  i_dato,
        output o_datoA,
        output o_datoB,
        output o_op,
        output o_valid,
        output o_state
    );

    modport master (
        output i_btn,
        output i_dato,
        input  o_datoA,
        input  o_datoB,
        input  o_op,
        input  o_valid,
        input  o_state
    );
endinterface

// File: rtl/operand_loader.sv
// Debounced push-button steps A -> B -> opcode capture from the shared switches; o_valid pulses on opcode load.
// A clean press loads DEB_CYCLES+3 edges after the button goes high; no backpressure, captures are unconditional.
module operand_loader #(
    parameter int NB_DATA    = 4,
    parameter int NB_OP      = 6,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              i_rst_n,
    operand_loader_if.slave   bus
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_A  = 2'b00,
        S_B  = 2'b01,
        S_OP = 2'b10
    } state_t;

    logic          sync_s1;
    logic          sync_s2;
    logic [CW-1:0] deb_cnt;
    logic          deb;
    logic          deb_d;
    logic          press;

    state_t state_q;
    state_t state_d;
    logic   ld_a;
    logic   ld_b;
    logic   ld_op;

    logic [NB_DATA-1:0] dato_a_q;
    logic [NB_DATA-1:0] dato_b_q;
    logic [NB_OP-1:0]   op_q;
    logic               valid_q;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_s1 <= 1'b0;
            sync_s2 <= 1'b0;
        end else begin
            sync_s1 <= bus.i_btn;
            sync_s2 <= sync_s1;
        end
    end

    // A level is accepted only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            deb_cnt <= '0;
            deb     <= 1'b0;
            deb_d   <= 1'b0;
        end else begin
            deb_d <= deb;
            if (sync_s2 == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CNT_LAST) begin
                deb     <= sync_s2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + CW'(1);
            end
        end
    end

    assign press = deb & ~deb_d;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        ld_op   = 1'b0;
        case (state_q)
            S_A: begin
                if (press) begin
                    ld_a    = 1'b1;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (press) begin
                    ld_b    = 1'b1;
                    state_d = S_OP;
                end
            end
            S_OP: begin
                if (press) begin
                    ld_op   = 1'b1;
                    state_d = S_A;
                end
            end
            // Unused encoding falls back to S_A without touching any capture.
            default: state_d = S_A;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dato_a_q <= '0;
            dato_b_q <= '0;
            op_q     <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= ld_op;
            if (ld_a) begin
                dato_a_q <= bus.i_dato[NB_DATA-1:0];
            end
            if (ld_b) begin
                dato_b_q <= bus.i_dato[NB_DATA-1:0];
            end
            if (ld_op) begin
                op_q <= bus.i_dato;
            end
        end
    end

    assign bus.o_datoA = dato_a_q;
    assign bus.o_datoB = dato_b_q;
    assign bus.o_op    = op_q;
    assign bus.o_valid = valid_q;
    assign bus.o_state = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with a short debounce window.
module tb_operand_loader;

    logic clk = 1'b0;
    logic i_rst_n;
    int   checks = 0;
    int   errors = 0;
    int   valid_cnt = 0;
    int   v0;

    always #5 clk = ~clk;

    operand_loader_if #(.NB_DATA(4), .NB_OP(6)) bus ();

    operand_loader #(
        .NB_DATA    (4),
        .NB_OP      (6),
        .DEB_CYCLES (4)
    ) dut (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always @(negedge clk) begin
        if (bus.o_valid === 1'b1) valid_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [5:0] d, input int hold);
        bus.i_dato = d;
        bus.i_btn  = 1'b1;
        cyc(hold);
        bus.i_btn  = 1'b0;
        cyc(10);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        cyc(2);
        i_rst_n = 1'b1;
    endtask

    initial begin
        // 1: reset and idle
        i_rst_n    = 1'b0;
        bus.i_btn  = 1'b0;
        bus.i_dato = 6'h00;
        cyc(3);
        chk("rst_a",     32'(bus.o_datoA), 32'h0);
        chk("rst_b",     32'(bus.o_datoB), 32'h0);
        chk("rst_op",    32'(bus.o_op),    32'h0);
        chk("rst_valid", 32'(bus.o_valid), 32'h0);
        chk("rst_state", 32'(bus.o_state), 32'h0);
        i_rst_n = 1'b1;
        v0 = valid_cnt;
        cyc(100);
        chk("idle_valid", 32'(valid_cnt - v0), 32'h0);
        chk("idle_state", 32'(bus.o_state),    32'h0);
        chk("idle_a",     32'(bus.o_datoA),    32'h0);

        // 3: button held through reset release; load at edge 7
        i_rst_n    = 1'b0;
        bus.i_btn  = 1'b1;
        bus.i_dato = 6'h07;
        cyc(2);
        i_rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("lat_e6_a",     32'(bus.o_datoA), 32'h0);
        chk("lat_e6_state", 32'(bus.o_state), 32'h0);
        @(posedge clk);
        #1;
        chk("lat_e7_a",     32'(bus.o_datoA), 32'h7);
        chk("lat_e7_state", 32'(bus.o_state), 32'h1);
        @(negedge clk);
        bus.i_btn = 1'b0;
        cyc(10);

        // 2: full triple
        do_reset();
        v0 = valid_cnt;
        press(6'h05, 10);
        chk("seq_a",      32'(bus.o_datoA), 32'h5);
        chk("seq_state1", 32'(bus.o_state), 32'h1);
        press(6'h03, 10);
        chk("seq_b",      32'(bus.o_datoB), 32'h3);
        chk("seq_state2", 32'(bus.o_state), 32'h2);
        chk("seq_novalid", 32'(valid_cnt - v0), 32'h0);
        press(6'h20, 10);
        chk("seq_op",     32'(bus.o_op),    32'h20);
        chk("seq_state0", 32'(bus.o_state), 32'h0);
        chk("seq_valid1", 32'(valid_cnt - v0), 32'h1);
        chk("seq_keep_a", 32'(bus.o_datoA), 32'h5);
        chk("seq_keep_b", 32'(bus.o_datoB), 32'h3);

        // 4: bounce glitches ignored, then one accepted press
        bus.i_dato = 6'h0C;
        for (int g = 0; g < 5; g++) begin
            bus.i_btn = 1'b1;
            cyc(3);
            bus.i_btn = 1'b0;
            cyc(3);
        end
        cyc(6);
        chk("bnc_state", 32'(bus.o_state), 32'h0);
        chk("bnc_a",     32'(bus.o_datoA), 32'h5);
        press(6'h09, 20);
        chk("bnc_hold_a",     32'(bus.o_datoA), 32'h9);
        chk("bnc_hold_state", 32'(bus.o_state), 32'h1);
        chk("bnc_hold_b",     32'(bus.o_datoB), 32'h3);

        // 5: asynchronous reset mid-cycle while in S_B
        @(posedge clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        chk("arst_a",     32'(bus.o_datoA), 32'h0);
        chk("arst_b",     32'(bus.o_datoB), 32'h0);
        chk("arst_op",    32'(bus.o_op),    32'h0);
        chk("arst_state", 32'(bus.o_state), 32'h0);
        cyc(2);
        i_rst_n = 1'b1;
        press(6'h06, 10);
        chk("arst_reload_a",     32'(bus.o_datoA), 32'h6);
        chk("arst_reload_state", 32'(bus.o_state), 32'h1);

        // 6: long hold gives one load; switches changing later are ignored
        do_reset();
        bus.i_dato = 6'h01;
        bus.i_btn  = 1'b1;
        cyc(12);
        chk("hold_a",     32'(bus.o_datoA), 32'h1);
        chk("hold_state", 32'(bus.o_state), 32'h1);
        bus.i_dato = 6'h0F;
        cyc(188);
        chk("hold_a_kept", 32'(bus.o_datoA), 32'h1);
        chk("hold_b_none", 32'(bus.o_datoB), 32'h0);
        chk("hold_state2", 32'(bus.o_state), 32'h1);
        bus.i_btn = 1'b0;
        cyc(10);
        chk("rel_state", 32'(bus.o_state), 32'h1);
        press(6'h0F, 10);
        chk("repress_b",     32'(bus.o_datoB), 32'hF);
        chk("repress_state", 32'(bus.o_state), 32'h2);
        chk("repress_a",     32'(bus.o_datoA), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
